// File: rtl/semaforo_param.sv
// Two-approach traffic light controller with pedestrian walk phase, all-red
// clearance and blinking night mode; every phase is timed in timebase ticks.
module semaforo_param #(
  parameter int unsigned CW        = 8,
  parameter int unsigned T_GREEN_A = 4,
  parameter int unsigned T_GREEN_B = 3,
  parameter int unsigned T_YELLOW  = 1,
  parameter int unsigned T_ALLRED  = 1,
  parameter int unsigned T_WALK    = 2,
  parameter int unsigned T_FLASH   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       modo,
  input  logic       ped_req,
  output logic       A_green,
  output logic       A_yellow,
  output logic       A_red,
  output logic       B_green,
  output logic       B_yellow,
  output logic       B_red,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [3:0] phase
);

  localparam int unsigned MAXT = (CW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CW) - 32'd1);

  if ((T_GREEN_A < 1) || (T_GREEN_A > MAXT) || (T_GREEN_B < 1) || (T_GREEN_B > MAXT) ||
      (T_YELLOW  < 1) || (T_YELLOW  > MAXT) || (T_ALLRED  < 1) || (T_ALLRED  > MAXT) ||
      (T_WALK    < 1) || (T_WALK    > MAXT) || (T_FLASH   < 1) || (T_FLASH   > MAXT)) begin : g_param_check
    $error("semaforo_param: every T_* must lie in 1..2^CW-1");
  end

  typedef enum logic [3:0] {
    A_GO      = 4'd0,
    A_YEL     = 4'd1,
    ALL_RED1  = 4'd2,
    B_GO      = 4'd3,
    B_YEL     = 4'd4,
    ALL_RED2  = 4'd5,
    PED_WALK  = 4'd6,
    FLASH_ON  = 4'd7,
    FLASH_OFF = 4'd8
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_pending;

  state_t          w_next;
  logic [CW-1:0]   w_last;
  logic            w_night;
  logic            w_expire;

  always_comb begin
    w_last = CW'(T_GREEN_A - 1);
    w_next = A_GO;
    case (r_state)
      A_GO:      begin w_last = CW'(T_GREEN_A - 1); w_next = A_YEL;    end
      A_YEL:     begin w_last = CW'(T_YELLOW  - 1); w_next = ALL_RED1; end
      ALL_RED1:  begin w_last = CW'(T_ALLRED  - 1); w_next = B_GO;     end
      B_GO:      begin w_last = CW'(T_GREEN_B - 1); w_next = B_YEL;    end
      B_YEL:     begin w_last = CW'(T_YELLOW  - 1); w_next = ALL_RED2; end
      ALL_RED2:  begin w_last = CW'(T_ALLRED  - 1); w_next = r_pending ? PED_WALK : A_GO; end
      PED_WALK:  begin w_last = CW'(T_WALK    - 1); w_next = A_GO;      end
      FLASH_ON:  begin w_last = CW'(T_FLASH   - 1); w_next = FLASH_OFF; end
      FLASH_OFF: begin w_last = CW'(T_FLASH   - 1); w_next = FLASH_ON;  end
      default:   begin w_last = '0;                 w_next = A_GO;      end
    endcase
  end

  assign w_night  = (r_state == FLASH_ON) || (r_state == FLASH_OFF);
  assign w_expire = tick && (r_cnt == w_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= A_GO;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (!w_night && modo) begin
      r_state   <= FLASH_ON;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (w_night && !modo) begin
      // leaving night mode always passes through an all-red clearance
      r_state <= ALL_RED2;
      r_cnt   <= '0;
    end else begin
      if (w_expire) begin
        r_state <= w_next;
        r_cnt   <= '0;
      end else if (tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // entering the walk phase serves the request; that clear beats a new press
      if (w_expire && (w_next == PED_WALK))
        r_pending <= 1'b0;
      else if (!w_night && (r_state != PED_WALK) && ped_req)
        r_pending <= 1'b1;
    end
  end

  always_comb begin
    {A_green, A_yellow, A_red, B_green, B_yellow, B_red, ped_walk} = '0;
    case (r_state)
      A_GO:      begin A_green  = 1'b1; B_red    = 1'b1; end
      A_YEL:     begin A_yellow = 1'b1; B_red    = 1'b1; end
      ALL_RED1,
      ALL_RED2:  begin A_red    = 1'b1; B_red    = 1'b1; end
      B_GO:      begin A_red    = 1'b1; B_green  = 1'b1; end
      B_YEL:     begin A_red    = 1'b1; B_yellow = 1'b1; end
      PED_WALK:  begin A_red    = 1'b1; B_red    = 1'b1; ped_walk = 1'b1; end
      FLASH_ON:  begin A_yellow = 1'b1; B_yellow = 1'b1; end
      default:   ;
    endcase
  end

  assign ped_pending = r_pending;
  assign phase       = r_state;

endmodule
